// File: rtl/simple_phase_sequencer.sv
// Multi-cycle instruction sequencer for the SIMPLE datapath: one-hot phase
// enables, run/stop/single-step control, memory stalls, sticky halt, retire count.
module simple_phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int ICNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  step,
  input  logic                  halt_req,
  input  logic                  mem_wait,
  output logic [NUM_PHASES-1:0] phase,
  output logic                  running,
  output logic                  halted,
  output logic [ICNT_WIDTH-1:0] instr_count,
  output logic [1:0]            state_dbg
);

  localparam int PH_W = $clog2(NUM_PHASES);
  localparam logic [PH_W-1:0] LAST_PH  = PH_W'(NUM_PHASES - 1);
  localparam logic [PH_W-1:0] STALL_PH = PH_W'(NUM_PHASES - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PH_W-1:0]       ph_q, ph_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  exec_prev_q, step_prev_q;
  logic [ICNT_WIDTH-1:0] icnt_q, icnt_d;

  logic exec_rise;
  logic step_rise;
  logic active;

  // A held button yields one edge; it re-arms only once sampled low.
  assign exec_rise = exec & ~exec_prev_q;
  assign step_rise = step & ~step_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      stop_pend_q <= 1'b0;
      exec_prev_q <= 1'b0;
      step_prev_q <= 1'b0;
      icnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      stop_pend_q <= stop_pend_d;
      exec_prev_q <= exec;
      step_prev_q <= step;
      icnt_q      <= icnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    stop_pend_d = stop_pend_q;
    icnt_d      = icnt_q;
    unique case (state_q)
      S_IDLE: begin
        ph_d = '0;
        if (exec_rise) begin
          state_d = S_RUN;
        end else if (step_rise) begin
          state_d = S_STEP;
        end
      end
      S_RUN, S_STEP: begin
        if (state_q == S_RUN && exec_rise) begin
          stop_pend_d = 1'b1;
        end
        if (ph_q == LAST_PH) begin
          // Retire: the instruction always finishes before any stop or halt.
          icnt_d = icnt_q + ICNT_WIDTH'(1);
          ph_d   = '0;
          if (halt_req) begin
            state_d     = S_HALT;
            stop_pend_d = 1'b0;
          end else if (state_q == S_STEP) begin
            state_d = S_IDLE;
          end else if (stop_pend_q) begin
            state_d     = S_IDLE;
            stop_pend_d = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end else if (ph_q == STALL_PH && mem_wait) begin
          ph_d = ph_q;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_HALT: begin
        state_d     = S_HALT;
        ph_d        = '0;
        stop_pend_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
      end
    endcase
  end

  assign active      = (state_q == S_RUN) || (state_q == S_STEP);
  assign phase       = active ? (NUM_PHASES'(1) << ph_q) : '0;
  assign running     = active;
  assign halted      = (state_q == S_HALT);
  assign instr_count = icnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_simple_phase_sequencer.sv
// Self-checking bench for simple_phase_sequencer: expected phase per cycle is
// queued with the stimulus and popped as each DUT cycle is observed.
module tb_simple_phase_sequencer;

  logic clk = 1'b0;
  logic reset, exec, step, halt_req, mem_wait;
  logic [4:0]  phase_a, phase_b;
  logic        running_a, running_b, halted_a, halted_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [1:0]  state_a, state_b;

  logic [4:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int total    = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  simple_phase_sequencer #(.NUM_PHASES(5), .ICNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .exec(exec), .step(step), .halt_req(halt_req),
    .mem_wait(mem_wait), .phase(phase_a), .running(running_a), .halted(halted_a),
    .instr_count(cnt_a), .state_dbg(state_a)
  );

  simple_phase_sequencer #(.NUM_PHASES(5), .ICNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .exec(exec), .step(step), .halt_req(halt_req),
    .mem_wait(mem_wait), .phase(phase_b), .running(running_b), .halted(halted_b),
    .instr_count(cnt_b), .state_dbg(state_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_drive();
    @(posedge clk); #1;
  endtask

  task automatic push_instr(input int n);
    for (int k = 0; k < n * 5; k++) exp_q.push_back(5'd1 << (k % 5));
  endtask

  task automatic test_reset();
    reset = 1'b1; exec = 1'b0; step = 1'b0; halt_req = 1'b0; mem_wait = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (phase_a !== 5'd0 || running_a !== 1'b0 || halted_a !== 1'b0 || cnt_a !== 16'd0 || cnt_b !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: phase=%b run=%b halt=%b cnt=%0d/%0d, want 0/0/0/0/0",
               phase_a, running_a, halted_a, cnt_a, cnt_b);
    end
    next_drive();
    reset = 1'b0;
    next_drive();
    @(negedge clk);
    checks++;
    if (phase_a !== 5'd0 || state_a !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_idle: phase=%b state=%0d, want 00000 IDLE", phase_a, state_a);
    end
    next_drive();
    total = 0;
  endtask

  task automatic test_run();
    logic [4:0] exp_v;
    exp_q.push_back(5'd0);
    push_instr(3);
    for (int i = 0; i < 16; i++) begin
      exec = (i == 0);
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL run_q_empty cycle %0d", i);
      end else begin
        exp_v = exp_q.pop_front();
        if (phase_a !== exp_v || phase_b !== exp_v || running_a !== (exp_v != 5'd0)) begin
          failures++;
          $display("FAIL run_phase cycle %0d: got %b/%b run=%b, want %b", i, phase_a, phase_b, running_a, exp_v);
        end
      end
      next_drive();
    end
    total = 3;
    @(negedge clk);
    checks++;
    if (cnt_a !== 16'(total) || cnt_b !== 4'(total) || phase_a !== 5'b00001) begin
      failures++;
      $display("FAIL run_count: cnt=%0d/%0d phase=%b, want %0d and 00001", cnt_a, cnt_b, phase_a, total);
    end
    next_drive();
  endtask

  task automatic test_stop();
    logic [4:0] exp_v;
    exp_q.push_back(5'b00010); exp_q.push_back(5'b00100);
    exp_q.push_back(5'b01000); exp_q.push_back(5'b10000);
    exp_q.push_back(5'd0);     exp_q.push_back(5'd0);
    for (int i = 0; i < 6; i++) begin
      exec = (i < 2);
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL stop_q_empty cycle %0d", i);
      end else begin
        exp_v = exp_q.pop_front();
        if (phase_a !== exp_v || phase_b !== exp_v || running_a !== (exp_v != 5'd0)) begin
          failures++;
          $display("FAIL stop_phase cycle %0d: got %b/%b run=%b, want %b", i, phase_a, phase_b, running_a, exp_v);
        end
      end
      next_drive();
    end
    total = 4;
    @(negedge clk);
    checks++;
    if (cnt_a !== 16'(total) || running_a !== 1'b0 || state_a !== ST_IDLE) begin
      failures++;
      $display("FAIL stop_count: cnt=%0d run=%b state=%0d, want %0d 0 IDLE", cnt_a, running_a, state_a, total);
    end
    next_drive();
  endtask

  task automatic test_step();
    logic [4:0] exp_v;
    exp_q.push_back(5'd0);
    push_instr(1);
    repeat (16) exp_q.push_back(5'd0);
    for (int i = 0; i < 22; i++) begin
      step = (i < 20);
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL step_q_empty cycle %0d", i);
      end else begin
        exp_v = exp_q.pop_front();
        if (phase_a !== exp_v || phase_b !== exp_v || running_a !== (exp_v != 5'd0)) begin
          failures++;
          $display("FAIL step_phase cycle %0d: got %b/%b run=%b, want %b", i, phase_a, phase_b, running_a, exp_v);
        end
      end
      next_drive();
    end
    total = 5;
    @(negedge clk);
    checks++;
    if (cnt_a !== 16'(total) || state_a !== ST_IDLE) begin
      failures++;
      $display("FAIL step_count: cnt=%0d state=%0d, want %0d IDLE", cnt_a, state_a, total);
    end
    next_drive();
  endtask

  task automatic test_stall();
    logic [4:0] exp_v;
    exp_q.push_back(5'd0);
    exp_q.push_back(5'b00001); exp_q.push_back(5'b00010); exp_q.push_back(5'b00100);
    repeat (4) exp_q.push_back(5'b01000);
    exp_q.push_back(5'b10000);
    exp_q.push_back(5'd0); exp_q.push_back(5'd0);
    for (int i = 0; i < 11; i++) begin
      exec     = (i == 0) || (i >= 2 && i < 5);
      mem_wait = (i == 1) || (i >= 4 && i < 7);
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL stall_q_empty cycle %0d", i);
      end else begin
        exp_v = exp_q.pop_front();
        if (phase_a !== exp_v || phase_b !== exp_v || running_a !== (exp_v != 5'd0)) begin
          failures++;
          $display("FAIL stall_phase cycle %0d: got %b/%b run=%b, want %b", i, phase_a, phase_b, running_a, exp_v);
        end
      end
      next_drive();
    end
    mem_wait = 1'b0;
    exec = 1'b0;
    total = 6;
    @(negedge clk);
    checks++;
    if (cnt_a !== 16'(total) || cnt_b !== 4'(total)) begin
      failures++;
      $display("FAIL stall_count: cnt=%0d/%0d, want %0d", cnt_a, cnt_b, total);
    end
    next_drive();
  endtask

  task automatic test_halt();
    logic [4:0] exp_v;
    exp_q.push_back(5'd0);
    push_instr(1);
    repeat (9) exp_q.push_back(5'd0);
    for (int i = 0; i < 15; i++) begin
      exec     = (i == 0) || (i == 7);
      step     = (i == 9);
      halt_req = (i == 2) || (i == 5);
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL halt_q_empty cycle %0d", i);
      end else begin
        exp_v = exp_q.pop_front();
        if (phase_a !== exp_v || running_a !== (exp_v != 5'd0) || halted_a !== (i >= 6)) begin
          failures++;
          $display("FAIL halt_phase cycle %0d: got %b run=%b halted=%b, want %b halted=%b",
                   i, phase_a, running_a, halted_a, exp_v, (i >= 6));
        end
      end
      next_drive();
    end
    halt_req = 1'b0;
    total = 7;
    @(negedge clk);
    checks++;
    if (cnt_a !== 16'(total) || halted_a !== 1'b1) begin
      failures++;
      $display("FAIL halt_sticky: cnt=%0d halted=%b, want %0d 1", cnt_a, halted_a, total);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (phase_a !== 5'd0 || running_a !== 1'b0 || halted_a !== 1'b0 || cnt_a !== 16'd0 || cnt_b !== 4'd0) begin
      failures++;
      $display("FAIL halt_reset: phase=%b run=%b halted=%b cnt=%0d/%0d, want all 0",
               phase_a, running_a, halted_a, cnt_a, cnt_b);
    end
    total = 0;
    next_drive();
    reset = 1'b0;
    next_drive();
  endtask

  task automatic test_simul_wrap();
    logic [4:0] exp_v;
    exp_q.push_back(5'd0);
    push_instr(17);
    exp_q.push_back(5'd0); exp_q.push_back(5'd0);
    exp_q.push_back(5'b00001); exp_q.push_back(5'b00010); exp_q.push_back(5'b00100);
    for (int i = 0; i < 90; i++) begin
      exec = (i == 0) || (i == 82) || (i == 87);
      step = (i == 0);
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL wrap_q_empty cycle %0d", i);
      end else begin
        exp_v = exp_q.pop_front();
        if (phase_a !== exp_v || phase_b !== exp_v || running_a !== (exp_v != 5'd0)) begin
          failures++;
          $display("FAIL wrap_phase cycle %0d: got %b/%b run=%b, want %b", i, phase_a, phase_b, running_a, exp_v);
        end
      end
      if (i == 1) begin
        checks++;
        if (state_a !== ST_RUN) begin
          failures++; $display("FAIL simul_exec_wins: state=%0d, want %0d", state_a, ST_RUN);
        end
      end
      if (i == 86) begin
        total = 17;
        checks++;
        if (cnt_a !== 16'(total) || cnt_b !== 4'(total)) begin
          failures++; $display("FAIL wrap_count: cnt=%0d/%0d, want %0d/%0d", cnt_a, cnt_b, total, 4'(total));
        end
      end
      next_drive();
    end
    @(negedge clk);
    checks++;
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
    if (phase_a !== exp_v) begin
      failures++; $display("FAIL wrap_pre_reset: phase=%b, want %b", phase_a, exp_v);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (phase_a !== 5'd0 || running_a !== 1'b0 || state_a !== ST_IDLE || cnt_a !== 16'd0 || cnt_b !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset: phase=%b run=%b state=%0d cnt=%0d/%0d, want 0 0 IDLE 0/0",
               phase_a, running_a, state_a, cnt_a, cnt_b);
    end
    total = 0;
    next_drive();
    reset = 1'b0;
    exec  = 1'b0;
    step  = 1'b0;
    next_drive();
  endtask

  initial begin
    test_reset();
    test_run();
    test_stop();
    test_step();
    test_stall();
    test_halt();
    test_simul_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
